icache_nway_ctrl: RTL and testbench

Parametrised N-way set-associative instruction-cache controller sitting between the IF stage and the L2 cache. It drives externally instantiated tag/data arrays (one pair per way), detects hits combinationally and forwards the selected word to IF. On a miss it performs a latched-address line refill from L2 with per-set round-robin replacement. A whole-cache invalidate (flush) walk extends the previous fixed 2-way controller.

---
 rtl/icache_pkg.sv | 31 +++
 rtl/icache_nway_ctrl_victim_sel.sv | 26 ++
 rtl/icache_nway_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_icache_nway_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and helpers for the N-way instruction-cache controller.
package icache_pkg;

  typedef enum logic [2:0] {
    ST_ACCESS,
    ST_WAIT_BUSY,
    ST_REQ,
    ST_REFILL,
    ST_FLUSH
  } state_e;

  localparam logic READ    = 1'b0;
  localparam logic WRITE   = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic ENABLE  = 1'b1;

  // Widest line the word selector handles (16 words).
  localparam int MAX_OFF_W  = 4;
  localparam int MAX_LINE_W = 32 << MAX_OFF_W;

  // The valid flag sits directly above the tag in each way's {valid,tag} field.
  function automatic int valid_pos(input int tag_w);
    return tag_w;
  endfunction

  function automatic logic [31:0] word_sel(input logic [MAX_LINE_W-1:0] line,
                                           input logic [MAX_OFF_W-1:0]  off);
    return line[{off, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/icache_nway_ctrl_victim_sel.sv
// Replacement victim: lowest-numbered invalid way, else the set's round-robin pointer.
module icache_victim_sel #(
  parameter  int WAYS  = 2,
  localparam int PTR_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [WAYS-1:0]  victim_o,
  output logic             use_ptr_o
);

  always_comb begin
    victim_o  = '0;
    use_ptr_o = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_o  = WAYS'(1) << w;
        use_ptr_o = 1'b0;
      end
    end
    if (use_ptr_o) begin
      victim_o[ptr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/icache_nway_ctrl.sv
// N-way set-associative I-cache controller: zero-latency hits, latched-address L2 refill,
// per-set round-robin replacement and a whole-cache invalidate walk.
module icache_nway_ctrl
  import icache_pkg::*;
#(
  parameter  int ADDR_W  = 30,
  parameter  int WAYS    = 2,
  parameter  int INDEX_W = 8,
  parameter  int OFF_W   = 2,
  localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W,
  localparam int LINE_W  = 32 << OFF_W,
  localparam int ENT_W   = TAG_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic [31:0]             cpu_data,
  output logic                    data_rdy,
  output logic                    miss_stall,
  input  logic                    flush,
  output logic                    flush_busy,
  output logic [INDEX_W-1:0]      index,
  input  logic [WAYS*ENT_W-1:0]   tag_rd,
  input  logic [WAYS*LINE_W-1:0]  data_rd,
  output logic [WAYS-1:0]         tag_we,
  output logic [WAYS-1:0]         data_we,
  output logic [ENT_W-1:0]        tag_wd,
  output logic [LINE_W-1:0]       data_wd,
  output logic                    l2_req,
  output logic [ADDR_W-OFF_W-1:0] l2_addr,
  input  logic                    l2_busy,
  input  logic                    l2_rdy,
  input  logic [LINE_W-1:0]       l2_data
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int PTR_W = $clog2(WAYS);
  localparam int VLD   = valid_pos(TAG_W);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    miss_addr_q;
  logic [LINE_W-1:0]    line_buf_q;
  logic                 flush_pend_q;
  logic                 l2_req_q;
  logic [INDEX_W-1:0]   flush_cnt_q;
  logic [PTR_W-1:0]     ptr_q [SETS];

  logic [TAG_W-1:0]     if_tag, miss_tag;
  logic [INDEX_W-1:0]   if_idx, miss_idx;
  logic [OFF_W-1:0]     if_off, miss_off;
  logic [WAYS-1:0]      valid_w, hit_w, victim;
  logic [PTR_W-1:0]     hit_idx;
  logic [LINE_W-1:0]    hit_line;
  logic                 hit, use_ptr;

  assign if_tag   = if_addr[ADDR_W-1 -: TAG_W];
  assign if_idx   = if_addr[OFF_W +: INDEX_W];
  assign if_off   = if_addr[OFF_W-1:0];
  assign miss_tag = miss_addr_q[ADDR_W-1 -: TAG_W];
  assign miss_idx = miss_addr_q[OFF_W +: INDEX_W];
  assign miss_off = miss_addr_q[OFF_W-1:0];

  // Multiple hit ways are illegal; descending scan lets the lowest way win.
  always_comb begin
    valid_w = '0;
    hit_w   = '0;
    hit_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      valid_w[w] = tag_rd[w*ENT_W + VLD];
      hit_w[w]   = valid_w[w] && (tag_rd[w*ENT_W +: TAG_W] == if_tag);
      if (hit_w[w]) begin
        hit_idx = PTR_W'(w);
      end
    end
  end

  assign hit      = |hit_w;
  assign hit_line = data_rd[hit_idx*LINE_W +: LINE_W];

  icache_victim_sel #(.WAYS(WAYS)) u_victim (
    .valid_i   (valid_w),
    .ptr_i     (ptr_q[miss_idx]),
    .victim_o  (victim),
    .use_ptr_o (use_ptr)
  );

  always_comb begin
    state_d    = state_q;
    index      = if_idx;
    tag_we     = {WAYS{READ}};
    data_we    = {WAYS{READ}};
    tag_wd     = '0;
    data_wd    = line_buf_q;
    data_rdy   = DISABLE;
    miss_stall = DISABLE;
    cpu_data   = '0;
    case (state_q)
      ST_ACCESS: begin
        if (flush_pend_q) begin
          miss_stall = if_req;
          state_d    = ST_FLUSH;
        end else if (if_req && hit) begin
          data_rdy = ENABLE;
          cpu_data = word_sel(MAX_LINE_W'(hit_line), MAX_OFF_W'(if_off));
        end else if (if_req) begin
          miss_stall = ENABLE;
          state_d    = l2_busy ? ST_WAIT_BUSY : ST_REQ;
        end
      end
      ST_WAIT_BUSY: begin
        miss_stall = ENABLE;
        if (!l2_busy) state_d = ST_REQ;
      end
      ST_REQ: begin
        miss_stall = ENABLE;
        if (l2_rdy) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        index    = miss_idx;
        tag_we   = victim;
        data_we  = victim;
        tag_wd   = {1'b1, miss_tag};
        data_rdy = ENABLE;
        cpu_data = word_sel(MAX_LINE_W'(line_buf_q), MAX_OFF_W'(miss_off));
        state_d  = ST_ACCESS;
      end
      ST_FLUSH: begin
        index      = flush_cnt_q;
        tag_we     = {WAYS{WRITE}};
        miss_stall = if_req;
        if (flush_cnt_q == {INDEX_W{1'b1}}) state_d = ST_ACCESS;
      end
      default: state_d = ST_ACCESS;
    endcase
    // Nothing may be written or returned while reset is held.
    if (rst) begin
      tag_we     = '0;
      data_we    = '0;
      data_rdy   = DISABLE;
      miss_stall = DISABLE;
      cpu_data   = '0;
    end
  end

  assign flush_busy = !rst && (flush_pend_q || state_q == ST_FLUSH);
  assign l2_req     = l2_req_q;
  assign l2_addr    = miss_addr_q[ADDR_W-1:OFF_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCESS;
      miss_addr_q  <= '0;
      line_buf_q   <= '0;
      flush_pend_q <= 1'b0;
      l2_req_q     <= 1'b0;
      flush_cnt_q  <= '0;
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
    end else begin
      state_q  <= state_d;
      l2_req_q <= (state_d == ST_REQ);
      if (state_q == ST_ACCESS && !flush_pend_q && if_req && !hit) begin
        miss_addr_q <= if_addr;
      end
      if (state_q == ST_REQ && l2_rdy) begin
        line_buf_q <= l2_data;
      end
      if (state_q == ST_ACCESS && flush_pend_q) begin
        flush_pend_q <= 1'b0;
      end else if (flush && state_q != ST_FLUSH) begin
        flush_pend_q <= 1'b1;
      end
      if (state_q == ST_FLUSH) begin
        flush_cnt_q        <= flush_cnt_q + 1'b1;
        ptr_q[flush_cnt_q] <= '0;
      end
      if (state_q == ST_REFILL && use_ptr) begin
        ptr_q[miss_idx] <= ptr_q[miss_idx] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_nway_ctrl.sv
// Bench for icache_nway_ctrl: a 2-way and a 4-way instance sharing L2 stimulus, behavioural arrays.
module tb_icache_nway_ctrl;

  localparam int AW = 30;
  localparam int TW = 20;
  localparam int EW = 21;
  localparam int LW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, mem_init, dsel, if_req, flush, l2_busy, l2_rdy;
  logic [AW-1:0] if_addr;
  logic [LW-1:0] l2_data;

  logic          if_req2, if_req4, flush2, flush4;
  logic [31:0]   cpu_data2, cpu_data4;
  logic          data_rdy2, data_rdy4, miss_stall2, miss_stall4, flush_busy2, flush_busy4;
  logic [7:0]    index2, index4;
  logic [2*EW-1:0] tag_rd2;
  logic [4*EW-1:0] tag_rd4;
  logic [2*LW-1:0] data_rd2;
  logic [4*LW-1:0] data_rd4;
  logic [1:0]    tag_we2, data_we2;
  logic [3:0]    tag_we4, data_we4;
  logic [EW-1:0] tag_wd2, tag_wd4;
  logic [LW-1:0] data_wd2, data_wd4;
  logic          l2_req2, l2_req4;
  logic [27:0]   l2_addr2, l2_addr4;

  assign if_req2 = if_req & ~dsel;
  assign if_req4 = if_req & dsel;
  assign flush2  = flush & ~dsel;
  assign flush4  = flush & dsel;

  logic [31:0] cpu_data_s;
  logic        data_rdy_s, miss_stall_s, flush_busy_s, l2_req_s;
  logic [3:0]  tag_we_s, data_we_s;
  logic [27:0] l2_addr_s;
  assign cpu_data_s   = dsel ? cpu_data4   : cpu_data2;
  assign data_rdy_s   = dsel ? data_rdy4   : data_rdy2;
  assign miss_stall_s = dsel ? miss_stall4 : miss_stall2;
  assign flush_busy_s = dsel ? flush_busy4 : flush_busy2;
  assign l2_req_s     = dsel ? l2_req4     : l2_req2;
  assign l2_addr_s    = dsel ? l2_addr4    : l2_addr2;
  assign tag_we_s     = dsel ? tag_we4     : {2'b00, tag_we2};
  assign data_we_s    = dsel ? data_we4    : {2'b00, data_we2};

  icache_nway_ctrl #(.ADDR_W(AW), .WAYS(2), .INDEX_W(8), .OFF_W(2)) d2 (
    .clk(clk), .rst(rst), .if_req(if_req2), .if_addr(if_addr), .cpu_data(cpu_data2),
    .data_rdy(data_rdy2), .miss_stall(miss_stall2), .flush(flush2), .flush_busy(flush_busy2),
    .index(index2), .tag_rd(tag_rd2), .data_rd(data_rd2), .tag_we(tag_we2), .data_we(data_we2),
    .tag_wd(tag_wd2), .data_wd(data_wd2), .l2_req(l2_req2), .l2_addr(l2_addr2),
    .l2_busy(l2_busy), .l2_rdy(l2_rdy), .l2_data(l2_data)
  );

  icache_nway_ctrl #(.ADDR_W(AW), .WAYS(4), .INDEX_W(8), .OFF_W(2)) d4 (
    .clk(clk), .rst(rst), .if_req(if_req4), .if_addr(if_addr), .cpu_data(cpu_data4),
    .data_rdy(data_rdy4), .miss_stall(miss_stall4), .flush(flush4), .flush_busy(flush_busy4),
    .index(index4), .tag_rd(tag_rd4), .data_rd(data_rd4), .tag_we(tag_we4), .data_we(data_we4),
    .tag_wd(tag_wd4), .data_wd(data_wd4), .l2_req(l2_req4), .l2_addr(l2_addr4),
    .l2_busy(l2_busy), .l2_rdy(l2_rdy), .l2_data(l2_data)
  );

  // Behavioural tag/data arrays: combinational read, clocked write.
  logic [EW-1:0] tmem2 [2][256];
  logic [LW-1:0] dmem2 [2][256];
  logic [EW-1:0] tmem4 [4][256];
  logic [LW-1:0] dmem4 [4][256];

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      tag_rd2[w*EW +: EW]  = tmem2[w][index2];
      data_rd2[w*LW +: LW] = dmem2[w][index2];
    end
    for (int w = 0; w < 4; w++) begin
      tag_rd4[w*EW +: EW]  = tmem4[w][index4];
      data_rd4[w*LW +: LW] = dmem4[w][index4];
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int w = 0; w < 4; w++)
        for (int s = 0; s < 256; s++) begin
          tmem4[w][s] <= '0;
          if (w < 2) tmem2[w][s] <= '0;
        end
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (tag_we2[w])  tmem2[w][index2] <= tag_wd2;
        if (data_we2[w]) dmem2[w][index2] <= data_wd2;
      end
      for (int w = 0; w < 4; w++) begin
        if (tag_we4[w])  tmem4[w][index4] <= tag_wd4;
        if (data_we4[w]) dmem4[w][index4] <= data_wd4;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] mkword(input logic [AW-1:0] a);
    return {2'b00, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [LW-1:0] line_of(input logic [27:0] la);
    logic [LW-1:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = mkword({la, 2'(i)});
    return l;
  endfunction

  // One fetch: hit checked same cycle; miss walks busy/REQ/REFILL with l2_rdy on the 4th REQ cycle.
  task automatic fetch(input logic [AW-1:0] a, input bit exp_hit, input logic [3:0] exp_we,
                       input int busy, input bit flush_in_req);
    logic [31:0] exp;
    exp_q.push_back(mkword(a));
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a; l2_busy = (busy > 0);
    @(negedge clk);
    if (exp_hit) begin
      exp = exp_q.pop_front();
      checks++;
      if (data_rdy_s !== 1'b1 || cpu_data_s !== exp) begin
        errors++;
        $display("FAIL hit addr=%h rdy=%b data=%h expected rdy=1 data=%h", a, data_rdy_s, cpu_data_s, exp);
      end
    end else begin
      checks++;
      if (miss_stall_s !== 1'b1 || data_rdy_s !== 1'b0) begin
        errors++;
        $display("FAIL miss_detect addr=%h stall=%b rdy=%b expected 1/0", a, miss_stall_s, data_rdy_s);
      end
      for (int c = 1; c <= busy; c++) begin
        @(posedge clk); #1;
        l2_busy = (c < busy);
        @(negedge clk);
        checks++;
        if (l2_req_s !== 1'b0 || miss_stall_s !== 1'b1) begin
          errors++;
          $display("FAIL wait_busy cycle=%0d l2_req=%b stall=%b expected 0/1", c, l2_req_s, miss_stall_s);
        end
      end
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (flush_in_req) flush = (c == 0);
        if (c == 3) begin l2_rdy = 1'b1; l2_data = line_of(a[AW-1:2]); end
        @(negedge clk);
        checks++;
        if (l2_req_s !== 1'b1) begin
          errors++;
          $display("FAIL l2_req cycle=%0d got=%b expected 1", c, l2_req_s);
        end
        if (c == 0) begin
          checks++;
          if (l2_addr_s !== a[AW-1:2]) begin
            errors++;
            $display("FAIL l2_addr got=%h expected %h", l2_addr_s, a[AW-1:2]);
          end
        end
        if (flush_in_req && c == 2) begin
          checks++;
          if (flush_busy_s !== 1'b1) begin
            errors++;
            $display("FAIL flush_pending got=%b expected 1", flush_busy_s);
          end
        end
      end
      @(posedge clk); #1;
      l2_rdy = 1'b0; l2_data = '0;
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (data_rdy_s !== 1'b1 || cpu_data_s !== exp || miss_stall_s !== 1'b0) begin
        errors++;
        $display("FAIL refill_data addr=%h rdy=%b stall=%b data=%h expected 1/0 %h",
                 a, data_rdy_s, miss_stall_s, cpu_data_s, exp);
      end
      checks++;
      if (tag_we_s !== exp_we || data_we_s !== exp_we) begin
        errors++;
        $display("FAIL victim addr=%h tag_we=%b data_we=%b expected %b", a, tag_we_s, data_we_s, exp_we);
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1; dsel = 1'b0; if_req = 1'b0; flush = 1'b0;
    l2_busy = 1'b0; l2_rdy = 1'b0; l2_data = '0; if_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      dsel = d[0];
      #1;
      checks++;
      if ({data_rdy_s, miss_stall_s, flush_busy_s, l2_req_s, tag_we_s, data_we_s} !== 12'h000) begin
        errors++;
        $display("FAIL reset_strobes dut=%0d got=%b%b%b%b %b %b expected all 0", d,
                 data_rdy_s, miss_stall_s, flush_busy_s, l2_req_s, tag_we_s, data_we_s);
      end
      checks++;
      if (l2_addr_s !== '0 || cpu_data_s !== '0) begin
        errors++;
        $display("FAIL reset_data dut=%0d l2_addr=%h cpu_data=%h expected 0", d, l2_addr_s, cpu_data_s);
      end
    end
    dsel = 1'b0;
  endtask

  task automatic test_cold_miss();
    dsel = 1'b0;
    fetch(30'h100, 1'b0, 4'b0001, 0, 1'b0);
    fetch(30'h101, 1'b1, 4'b0000, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    dsel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 30'h100 + 30'(i ^ 3);
      exp_q.push_back(mkword(if_addr));
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (data_rdy_s !== 1'b1 || cpu_data_s !== exp) begin
        errors++;
        $display("FAIL b2b addr=%h rdy=%b data=%h expected 1 %h", if_addr, data_rdy_s, cpu_data_s, exp);
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic test_busy();
    dsel = 1'b0;
    fetch(30'h200, 1'b0, 4'b0001, 3, 1'b0);
  endtask

  task automatic test_flush();
    int n;
    n = 0;
    dsel = 1'b0;
    fetch(30'h300, 1'b0, 4'b0001, 0, 1'b1);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c == 21) begin
        checks++;
        if (miss_stall_s !== 1'b1 || data_rdy_s !== 1'b0) begin
          errors++;
          $display("FAIL flush_stall stall=%b rdy=%b expected 1/0", miss_stall_s, data_rdy_s);
        end
        if_req = 1'b0;
      end
      if (!flush_busy_s) break;
      n++;
      if (c == 10) flush = 1'b1;
      if (c == 11) flush = 1'b0;
      if (c == 20) begin if_req = 1'b1; if_addr = 30'h100; end
    end
    checks++;
    if (n != 257) begin
      errors++;
      $display("FAIL flush_len got=%0d expected 257", n);
    end
    fetch(30'h100, 1'b0, 4'b0001, 0, 1'b0);
    fetch(30'h300, 1'b0, 4'b0001, 0, 1'b0);
    fetch(30'h202, 1'b0, 4'b0001, 0, 1'b0);
  endtask

  task automatic test_eviction();
    dsel = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      fetch(30'(k * 'h400 + 'hC + (k & 3)), 1'b0, (k == 5) ? 4'b0001 : 4'(1 << (k - 1)), 0, 1'b0);
    end
    fetch(30'h80D, 1'b1, 4'b0000, 0, 1'b0);
    fetch(30'h180E, 1'b0, 4'b0010, 0, 1'b0);
    fetch(30'h40C, 1'b0, 4'b0100, 0, 1'b0);
    fetch(30'h140D, 1'b1, 4'b0000, 0, 1'b0);
    fetch(30'h180F, 1'b1, 4'b0000, 0, 1'b0);
  endtask

  task automatic test_spurious_rdy();
    dsel = 1'b1;
    @(posedge clk); #1;
    l2_rdy = 1'b1; l2_data = line_of(28'h0ABCDEF);
    @(negedge clk);
    checks++;
    if (data_rdy_s !== 1'b0 || tag_we_s !== 4'b0 || data_we_s !== 4'b0 || l2_req_s !== 1'b0) begin
      errors++;
      $display("FAIL spurious_rdy rdy=%b tag_we=%b data_we=%b l2_req=%b expected 0",
               data_rdy_s, tag_we_s, data_we_s, l2_req_s);
    end
    @(posedge clk); #1;
    l2_rdy = 1'b0; l2_data = '0;
    @(negedge clk);
    checks++;
    if (data_rdy_s !== 1'b0 || tag_we_s !== 4'b0) begin
      errors++;
      $display("FAIL spurious_after rdy=%b tag_we=%b expected 0", data_rdy_s, tag_we_s);
    end
  endtask

  task automatic test_reset_in_req();
    dsel = 1'b0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 30'h500;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (l2_req_s !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_req l2_req=%b expected 1", l2_req_s);
    end
    @(posedge clk); #1;
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (tag_we_s !== 4'b0 || data_we_s !== 4'b0) begin
      errors++;
      $display("FAIL rst_write tag_we=%b data_we=%b expected 0", tag_we_s, data_we_s);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (l2_req_s !== 1'b0) begin
      errors++;
      $display("FAIL rst_drop_req l2_req=%b expected 0", l2_req_s);
    end
    @(posedge clk); #1;
    l2_rdy = 1'b1; l2_data = line_of(30'h500 >> 2);
    @(negedge clk);
    checks++;
    if (data_rdy_s !== 1'b0 || tag_we_s !== 4'b0 || data_we_s !== 4'b0) begin
      errors++;
      $display("FAIL rst_late_rdy rdy=%b tag_we=%b data_we=%b expected 0", data_rdy_s, tag_we_s, data_we_s);
    end
    @(posedge clk); #1;
    l2_rdy = 1'b0; l2_data = '0;
    fetch(30'h500, 1'b0, 4'b0010, 0, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_busy();
    test_flush();
    test_eviction();
    test_spurious_rdy();
    test_reset_in_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
